score_bcd_digitizer: RTL
========================

// Module: score_bcd_digitizer
// PURPOSE
// Converts a binary HUD value (score, level, lives, countdown) into packed BCD digits.
// Uses an iterative double-dabble: one shift/add-3 step per clock.
// Sits directly upstream of the digit bitmap renderer and drives its 4-bit digit inputs.
// Also supplies a leading-zero blanking mask, which the rectangle logic ANDs into InsideRectangle.
// PARAMETERS
// BIN_WIDTH  20  width of binary input value
// DIGITS     6   number of BCD digits presented; digits[0] is least significant
// PORTS
// clk        in   1               system clock
// resetN     in   1               asynchronous active-low reset
// load       in   1               1-cycle request to convert value
// value      in   BIN_WIDTH       binary value; sampled on the load cycle only
// digits     out  DIGITS*4        [DIGITS-1:0][3:0] BCD result, registered
// digitEn    out  DIGITS          1 = digit visible (leading-zero blanking), registered
// valid      out  1               1-cycle pulse when digits/digitEn update
// busy       out  1               conversion in progress
// overflow   out  1               last result saturated; held until next update
// BEHAVIOUR
// Reset (async, resetN=0):
// - state=IDLE; digits=0; digitEn=1 on bit 0 only; valid=0; busy=0; overflow=0; pending=0.
// - Reset mid-conversion discards all work; no valid is issued.
// Internal scratch:
// - CONV_DIGITS=(BIN_WIDTH+2)/3 BCD nibbles plus a BIN_WIDTH shift register.
// - 5-bit step counter.
// FSM IDLE -> SHIFT -> DONE -> IDLE:
// - IDLE: on load=1, capture value into the shift register, clear scratch, counter=BIN_WIDTH,
//   go to SHIFT. busy rises on the next cycle.
// - SHIFT: each cycle, every scratch nibble >=5 gets +3 (nibble adds are independent, no carry).
//   Then {scratch,shiftreg} is shifted left by 1 and the counter is decremented.
//   Exit to DONE after BIN_WIDTH shifts.
// - DONE (1 cycle):
//   - If any scratch nibble at index >=DIGITS is nonzero: digits=all 9, overflow=1.
//     Otherwise digits=scratch[DIGITS-1:0], overflow=0.
//   - digitEn[i]=1 if i==0 or any digits[j]!=0 for j>=i.
//   - valid=1 for this single cycle only.
//   - busy=0 from the following cycle.
// - Exit from DONE: if pending=1, go to SHIFT with the latched value and clear pending;
//   otherwise return to IDLE.
// Latency and output stability:
// - load at cycle 0 -> valid and new digits at cycle BIN_WIDTH+1 (21 with defaults).
// - digits, digitEn and overflow change only on the valid cycle; they are stable between updates.
//   The renderer may sample them at any time.
// Loads while busy, or in the DONE cycle:
// - value is latched into a single pending register and pending=1.
// - A later load overwrites it (last-wins). No request is lost beyond the most recent one.
// - load and DONE in the same cycle: the load is captured as pending.
// Arithmetic:
// - Unsigned only. Max convertible value is 10^DIGITS-1; larger values saturate.
// TESTING
// 1. reset, load value=0 -> cycle 21: valid=1, digits=000000, digitEn=6'b000001, overflow=0.
// 2. load value=123456 -> digits[5..0]=1,2,3,4,5,6, digitEn=6'b111111, valid pulses once.
// 3. load value=1000000 -> digits=999999, overflow=1; then load 305 -> digits=000305,
//    digitEn=6'b000111, overflow=0.
// 4. load 7, then load 42 at cycle 5, then load 99 at cycle 9 -> valid at 21 with 7;
//    second valid at 42 with 99; 42 is never output.
// 5. load 654321, assert resetN=0 at cycle 10 for 2 cycles -> outputs at reset values,
//    no valid until the next load.
// 6. load 1048575 (all ones) -> overflow=1, digits=999999; busy high for exactly 21 cycles.

Source files
------------

// File: rtl/score_bcd_digitizer.sv
// score_bcd_digitizer
// Converts a binary HUD value into packed BCD digits using an iterative
// double-dabble, one shift/add-3 step per clock. The module also produces a
// leading-zero blanking mask for the digit renderer.
//
// Ports:
//   clk       system clock
//   resetN    asynchronous active-low reset
//   load      1-cycle request to convert value
//   value     binary input, sampled only on the load cycle
//   digits    [DIGITS-1:0][3:0] BCD result, registered; digits[0] is least significant
//   digitEn   1 = digit visible (leading-zero blanking), registered
//   valid     1-cycle pulse when digits/digitEn/overflow update
//   busy      conversion in progress
//   overflow  last result saturated to all nines; held until the next update
module score_bcd_digitizer #(
  parameter int unsigned BIN_WIDTH = 20,
  parameter int unsigned DIGITS    = 6
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   load,
  input  logic [BIN_WIDTH-1:0]   value,
  output logic [DIGITS-1:0][3:0] digits,
  output logic [DIGITS-1:0]      digitEn,
  output logic                   valid,
  output logic                   busy,
  output logic                   overflow
);

  localparam int unsigned CONV_DIGITS = (BIN_WIDTH + 2) / 3;
  localparam int unsigned CAT_W       = CONV_DIGITS * 4 + BIN_WIDTH;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e                        state_q;
  logic [CONV_DIGITS-1:0][3:0]   scratch_q;
  logic [BIN_WIDTH-1:0]          sr_q;
  logic [4:0]                    cnt_q;
  logic                          pending_q;
  logic [BIN_WIDTH-1:0]          pend_val_q;

  logic [CONV_DIGITS-1:0][3:0]   adj;
  logic [CONV_DIGITS-1:0][3:0]   shifted;
  logic [BIN_WIDTH-1:0]          sr_shifted;
  logic [CAT_W-1:0]              cat;
  logic                          res_ovf;
  logic [DIGITS-1:0][3:0]        res_digits;
  logic [DIGITS-1:0]             res_en;
  logic                          any_nz;
  logic [BIN_WIDTH-1:0]          start_val;

  // One double-dabble step: add-3 on every nibble >= 5, then shift left.
  always_comb begin
    for (int i = 0; i < int'(CONV_DIGITS); i++) begin
      adj[i] = (scratch_q[i] >= 4'd5) ? scratch_q[i] + 4'd3 : scratch_q[i];
    end
    cat        = {adj, sr_q};
    cat        = cat << 1;
    shifted    = cat[CAT_W-1:BIN_WIDTH];
    sr_shifted = cat[BIN_WIDTH-1:0];
  end

  // Result formatting, evaluated on the post-shift scratch so the final
  // shift and the output update land on the same edge.
  always_comb begin
    res_ovf = 1'b0;
    for (int i = int'(DIGITS); i < int'(CONV_DIGITS); i++) begin
      if (shifted[i] != 4'd0) res_ovf = 1'b1;
    end
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (res_ovf) begin
        res_digits[i] = 4'd9;
      end else if (i < int'(CONV_DIGITS)) begin
        res_digits[i] = shifted[i];
      end else begin
        res_digits[i] = 4'd0;
      end
    end
    // A digit is visible if it or any more significant digit is nonzero.
    any_nz = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      any_nz    = any_nz | (res_digits[i] != 4'd0);
      res_en[i] = any_nz | (i == 0);
    end
  end

  // In DONE a fresh load wins over an older pending value (last-wins).
  always_comb begin
    start_val = value;
    if (state_q == StDone && !load) start_val = pend_val_q;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= StIdle;
      scratch_q  <= '0;
      sr_q       <= '0;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      pend_val_q <= '0;
      digits     <= '0;
      digitEn    <= DIGITS'(1);
      valid      <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load) begin
            sr_q      <= start_val;
            scratch_q <= '0;
            cnt_q     <= 5'(BIN_WIDTH);
            busy      <= 1'b1;
            state_q   <= StShift;
          end
        end
        StShift: begin
          scratch_q <= shifted;
          sr_q      <= sr_shifted;
          cnt_q     <= cnt_q - 5'd1;
          if (load) begin
            pending_q  <= 1'b1;
            pend_val_q <= value;
          end
          if (cnt_q == 5'd1) begin
            digits   <= res_digits;
            digitEn  <= res_en;
            overflow <= res_ovf;
            valid    <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (load || pending_q) begin
            sr_q      <= start_val;
            scratch_q <= '0;
            cnt_q     <= 5'(BIN_WIDTH);
            pending_q <= 1'b0;
            state_q   <= StShift;
          end else begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
